gate_occupancy_ctrl: RTL and testbench
======================================

Name: gate_occupancy_ctrl

Overview:
- Sequences a 0..7 occupancy up/down counter from two physical push buttons: entry and exit.
- Synchronises and debounces both buttons, latches presses, and arbitrates simultaneous requests round-robin.
- Refuses entry when the counter reports full and exit when it reports empty.
- Drives the counter's active-low up/down strobes, then holds the gate open for a fixed time.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before the debounced level changes (range 1..15).
- OPEN_CYCLES, 8, cycles gate_open stays high after a granted step (range 1..255).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- btn_entry_n  input  1  raw entry button, active-low, asynchronous to clk
- btn_exit_n  input  1  raw exit button, active-low, asynchronous to clk
- cnt_full  input  1  counter full flag (occupancy 7)
- cnt_empty  input  1  counter empty flag (occupancy 0)
- up_n  output  1  counter increment strobe, active-low, one cycle
- down_n  output  1  counter decrement strobe, active-low, one cycle
- gate_open  output  1  gate actuator
- dir_entry  output  1  1 = current/last grant was entry, 0 = exit
- busy  output  1  high in any state other than IDLE
- deny_full  output  1  one-cycle pulse: entry refused because full
- deny_empty  output  1  one-cycle pulse: exit refused because empty

Behaviour:
- Reset (sampled at posedge clk while reset=1):
  - State IDLE; both synchroniser stages and debounced levels = 1 (released); debounce counters = 0.
  - Both pending flags = 0; round-robin pointer favours entry.
  - up_n = 1, down_n = 1, gate_open = 0, dir_entry = 0, busy = 0, deny_full = 0, deny_empty = 0.
- Input conditioning, per button:
  - 2-FF synchroniser.
  - Debounce counter increments while the synchronised value differs from the debounced level, and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
- Press detection: a 1->0 transition of the debounced level sets that button's pending flag on the same edge. Release is ignored. A press while already pending has no effect.
- Pending flags are captured in every state, including while busy. They clear only when that request is granted or denied.
- FSM states: IDLE, STEP, OPEN.
- IDLE:
  - No pending flag: stay in IDLE.
  - One pending: that request is the candidate.
  - Both pending: the candidate is the side the pointer favours; the pointer then favours the other side.
  - Candidate entry with cnt_full=1: pulse deny_full for one cycle, clear entry pending, stay in IDLE.
  - Candidate exit with cnt_empty=1: pulse deny_empty for one cycle, clear exit pending, stay in IDLE.
  - A denial consumes the arbitration turn. The other request, if pending, is evaluated on the next cycle.
  - Otherwise: clear candidate pending, set dir_entry, go to STEP.
- STEP (exactly 1 cycle):
  - up_n = 0 if dir_entry, else down_n = 0. The other strobe stays 1.
  - gate_open rises on entry to OPEN.
- OPEN:
  - gate_open = 1 for exactly OPEN_CYCLES cycles, then return to IDLE with gate_open = 0.
  - cnt_full/cnt_empty are sampled only in IDLE, so the one-cycle counter update latency after STEP is always covered.
- Strobes:
  - up_n and down_n are registered; they are never low simultaneously and never low outside STEP.
  - Exactly one strobe per grant.
- Throughput: at most one grant per 2 + OPEN_CYCLES cycles. An idle-to-idle transaction takes 1 (IDLE decision) + 1 (STEP) + OPEN_CYCLES cycles.
- Reset mid-operation: all state returns to reset values on that edge. A strobe in flight is withdrawn (returns to 1) and gate_open drops. Pending requests are discarded.
- Inconsistent flags (cnt_full and cnt_empty both 1): deny both directions as per the rules above. No lockup.

Test Plan:
- Reset, then hold btn_entry_n=0 with cnt_empty=1 -> after sync + DEBOUNCE_CYCLES + IDLE decision, exactly one up_n low cycle, then gate_open high for exactly 8 cycles, busy high throughout, down_n stays 1.
- btn_entry_n glitch low for 2 cycles (less than DEBOUNCE_CYCLES=4) -> no pending, no strobe, busy stays 0.
- Both buttons pressed on the same cycle, cnt_full=0, cnt_empty=0 -> entry granted first (up_n pulse), exit granted after OPEN completes (down_n pulse). A repeat of both -> exit first this time, because the pointer alternated.
- cnt_full=1, entry press -> deny_full one-cycle pulse, no up_n, gate stays closed. cnt_empty=1, exit press -> deny_empty pulse, no down_n.
- Exit pressed during an entry's OPEN phase -> down_n strobe follows immediately after OPEN ends via IDLE. A second entry press during the same OPEN is also served, in round-robin order.
- Assert reset during STEP and during OPEN -> up_n/down_n = 1 and gate_open = 0 on the next edge. Pending flags are cleared, and no grant occurs until a new debounced press.

Source files
------------

// File: rtl/gate_occupancy_ctrl.sv
// Gate occupancy sequencer: debounces entry/exit buttons, arbitrates requests
// round-robin, strobes the external 0..7 counter and holds the gate open.
module gate_occupancy_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int OPEN_CYCLES     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_entry_n,
    input  logic btn_exit_n,
    input  logic cnt_full,
    input  logic cnt_empty,
    output logic up_n,
    output logic down_n,
    output logic gate_open,
    output logic dir_entry,
    output logic busy,
    output logic deny_full,
    output logic deny_empty
);

    localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] OPEN_LAST = 8'(OPEN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, STEP, OPEN} state_t;

    // Index 0 = entry button, index 1 = exit button.
    logic [1:0] sync1, sync2, deb, press, pend, pend_nxt, clr;
    logic [3:0] db_cnt [2];

    state_t     state, state_nxt;
    logic [7:0] open_cnt, open_cnt_nxt;
    logic       rr_entry, rr_nxt, pick_entry;
    logic       up_n_nxt, down_n_nxt, gate_nxt, dir_nxt, df_nxt, de_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 2'b11;
            sync2     <= 2'b11;
            deb       <= 2'b11;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= {btn_exit_n, btn_entry_n};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 4'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // A press is the edge on which the debounced level falls 1->0.
    always_comb begin
        press = '0;
        for (int i = 0; i < 2; i++)
            press[i] = deb[i] & ~sync2[i] & (db_cnt[i] == DB_LAST);
    end

    always_comb begin
        state_nxt    = state;
        open_cnt_nxt = open_cnt;
        rr_nxt       = rr_entry;
        up_n_nxt     = 1'b1;
        down_n_nxt   = 1'b1;
        gate_nxt     = 1'b0;
        dir_nxt      = dir_entry;
        df_nxt       = 1'b0;
        de_nxt       = 1'b0;
        clr          = '0;
        pick_entry   = 1'b0;
        case (state)
            IDLE: begin
                if (|pend) begin
                    pick_entry = pend[0] & (~pend[1] | rr_entry);
                    if (&pend)
                        rr_nxt = ~pick_entry;
                    if (pick_entry) begin
                        clr[0] = 1'b1;
                        if (cnt_full) begin
                            df_nxt = 1'b1;
                        end else begin
                            dir_nxt   = 1'b1;
                            up_n_nxt  = 1'b0;
                            state_nxt = STEP;
                        end
                    end else begin
                        clr[1] = 1'b1;
                        if (cnt_empty) begin
                            de_nxt = 1'b1;
                        end else begin
                            dir_nxt    = 1'b0;
                            down_n_nxt = 1'b0;
                            state_nxt  = STEP;
                        end
                    end
                end
            end
            STEP: begin
                gate_nxt     = 1'b1;
                open_cnt_nxt = '0;
                state_nxt    = OPEN;
            end
            OPEN: begin
                if (open_cnt == OPEN_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    gate_nxt     = 1'b1;
                    open_cnt_nxt = open_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        pend_nxt = (pend & ~clr) | press;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            open_cnt   <= '0;
            pend       <= '0;
            rr_entry   <= 1'b1;
            up_n       <= 1'b1;
            down_n     <= 1'b1;
            gate_open  <= 1'b0;
            dir_entry  <= 1'b0;
            deny_full  <= 1'b0;
            deny_empty <= 1'b0;
        end else begin
            state      <= state_nxt;
            open_cnt   <= open_cnt_nxt;
            pend       <= pend_nxt;
            rr_entry   <= rr_nxt;
            up_n       <= up_n_nxt;
            down_n     <= down_n_nxt;
            gate_open  <= gate_nxt;
            dir_entry  <= dir_nxt;
            deny_full  <= df_nxt;
            deny_empty <= de_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_gate_occupancy_ctrl.sv
// Bench for gate_occupancy_ctrl: transaction-timer reference model compared
// every cycle, plus hand-computed latency/count expectations.
module tb_gate_occupancy_ctrl;

    localparam int DEB = 4;
    localparam int OPN = 8;

    logic clk, reset, btn_entry_n, btn_exit_n, cnt_full, cnt_empty;
    logic up_n, down_n, gate_open, dir_entry, busy, deny_full, deny_empty;

    gate_occupancy_ctrl #(.DEBOUNCE_CYCLES(DEB), .OPEN_CYCLES(OPN)) dut (
        .clk(clk), .reset(reset), .btn_entry_n(btn_entry_n), .btn_exit_n(btn_exit_n),
        .cnt_full(cnt_full), .cnt_empty(cnt_empty), .up_n(up_n), .down_n(down_n),
        .gate_open(gate_open), .dir_entry(dir_entry), .busy(busy),
        .deny_full(deny_full), .deny_empty(deny_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a transaction is a countdown of 1 + OPN busy cycles.
    bit [1:0] m_s1, m_s2, m_deb, m_pend;
    int       m_run [2];
    bit       m_rr_entry, m_dir, m_df, m_de;
    int       m_timer;

    always @(posedge clk) begin
        if (reset) begin
            m_s1 <= 2'b11; m_s2 <= 2'b11; m_deb <= 2'b11; m_pend <= 2'b00;
            m_run[0] <= 0; m_run[1] <= 0;
            m_rr_entry <= 1'b1; m_dir <= 1'b0; m_df <= 1'b0; m_de <= 1'b0;
            m_timer <= 0;
        end else begin
            bit [1:0] fall, np;
            bit take_entry, grant, df, de;
            np = m_pend; grant = 0; df = 0; de = 0; take_entry = 0;
            for (int b = 0; b < 2; b++)
                fall[b] = m_deb[b] && !m_s2[b] && (m_run[b] + 1 >= DEB);
            if (m_timer == 0 && m_pend != 2'b00) begin
                take_entry = m_pend[0] && (!m_pend[1] || m_rr_entry);
                if (m_pend == 2'b11) m_rr_entry <= !take_entry;
                if (take_entry) begin
                    np[0] = 0;
                    if (cnt_full) df = 1; else grant = 1;
                end else begin
                    np[1] = 0;
                    if (cnt_empty) de = 1; else grant = 1;
                end
            end
            if (grant) begin
                m_timer <= 1 + OPN;
                m_dir   <= take_entry;
            end else if (m_timer > 0) begin
                m_timer <= m_timer - 1;
            end
            m_df   <= df;
            m_de   <= de;
            m_pend <= np | fall;
            for (int b = 0; b < 2; b++) begin
                if (m_s2[b] != m_deb[b]) begin
                    if (m_run[b] + 1 >= DEB) begin
                        m_deb[b] <= m_s2[b];
                        m_run[b] <= 0;
                    end else begin
                        m_run[b] <= m_run[b] + 1;
                    end
                end else begin
                    m_run[b] <= 0;
                end
            end
            m_s1 <= {btn_exit_n, btn_entry_n};
            m_s2 <= m_s1;
        end
    end

    int checks = 0, errors = 0, cyc = 0;
    int n_up = 0, n_down = 0, n_gate = 0, n_busy = 0, n_df = 0, n_de = 0;
    bit slog [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One cycle: wait for the falling edge, compare against the model, log events.
    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("up_n",       up_n,       !(m_timer == OPN + 1 && m_dir));
        chk("down_n",     down_n,     !(m_timer == OPN + 1 && !m_dir));
        chk("gate_open",  gate_open,  (m_timer >= 1 && m_timer <= OPN));
        chk("busy",       busy,       (m_timer > 0));
        chk("dir_entry",  dir_entry,  m_dir);
        chk("deny_full",  deny_full,  m_df);
        chk("deny_empty", deny_empty, m_de);
        if (!up_n)      begin n_up++;   slog.push_back(1'b1); end
        if (!down_n)    begin n_down++; slog.push_back(1'b0); end
        if (gate_open)  n_gate++;
        if (busy)       n_busy++;
        if (deny_full)  n_df++;
        if (deny_empty) n_de++;
    endtask

    int b_up, b_down, b_gate, b_busy, b_df, b_de, b_log;
    task automatic snap();
        b_up = n_up; b_down = n_down; b_gate = n_gate; b_busy = n_busy;
        b_df = n_df; b_de = n_de; b_log = slog.size();
    endtask

    initial begin
        bit found;
        reset = 1; btn_entry_n = 1; btn_exit_n = 1; cnt_full = 0; cnt_empty = 0;
        repeat (3) tick();
        chk("rst_up_n", up_n, 1); chk("rst_down_n", down_n, 1);
        chk("rst_gate", gate_open, 0); chk("rst_busy", busy, 0); chk("rst_dir", dir_entry, 0);
        reset = 0;
        repeat (3) tick();

        // Held entry press, counter empty: up_n low 7 cycles after the drive.
        cnt_empty = 1; snap(); btn_entry_n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 6)  chk("t1_up_early", up_n, 1);
            if (i == 7)  begin chk("t1_up_low", up_n, 0); chk("t1_busy", busy, 1); end
            if (i == 8)  begin chk("t1_up_back", up_n, 1); chk("t1_gate_rise", gate_open, 1); end
            if (i == 15) chk("t1_gate_last", gate_open, 1);
            if (i == 16) begin chk("t1_gate_fall", gate_open, 0); chk("t1_idle", busy, 0); end
        end
        chk("t1_n_up", n_up - b_up, 1); chk("t1_n_down", n_down - b_down, 0);
        chk("t1_n_gate", n_gate - b_gate, OPN); chk("t1_n_busy", n_busy - b_busy, OPN + 1);
        btn_entry_n = 1; repeat (12) tick();

        // Two-cycle glitch is filtered out.
        cnt_empty = 0; snap(); btn_entry_n = 0;
        repeat (2) tick();
        btn_entry_n = 1; repeat (20) tick();
        chk("glitch_busy", n_busy - b_busy, 0); chk("glitch_up", n_up - b_up, 0);

        // Simultaneous presses: entry first, then pointer alternates.
        for (int r = 0; r < 2; r++) begin
            snap(); btn_entry_n = 0; btn_exit_n = 0;
            repeat (8) tick();
            btn_entry_n = 1; btn_exit_n = 1;
            repeat (40) tick();
            chk("both_count", slog.size() - b_log, 2);
            if (slog.size() - b_log == 2) begin
                chk("both_first",  slog[b_log],     (r == 0) ? 1 : 0);
                chk("both_second", slog[b_log + 1], (r == 0) ? 0 : 1);
            end
        end

        // Denials.
        cnt_full = 1; snap(); btn_entry_n = 0; repeat (8) tick(); btn_entry_n = 1; repeat (15) tick();
        chk("dfull_pulse", n_df - b_df, 1); chk("dfull_up", n_up - b_up, 0); chk("dfull_gate", n_gate - b_gate, 0);
        cnt_full = 0; cnt_empty = 1;
        snap(); btn_exit_n = 0; repeat (8) tick(); btn_exit_n = 1; repeat (15) tick();
        chk("dempty_pulse", n_de - b_de, 1); chk("dempty_down", n_down - b_down, 0);
        cnt_empty = 0;

        // Exit and a fresh entry press arrive while the gate is open.
        snap(); btn_entry_n = 0; repeat (6) tick(); btn_entry_n = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin tick(); if (gate_open) found = 1; end
        chk("ovl_gate_seen", found, 1);
        btn_exit_n = 0; repeat (4) tick();
        btn_entry_n = 0; repeat (10) tick();
        btn_entry_n = 1; btn_exit_n = 1; repeat (50) tick();
        chk("ovl_count", slog.size() - b_log, 3);
        if (slog.size() - b_log == 3) begin
            chk("ovl_1", slog[b_log], 1); chk("ovl_2", slog[b_log + 1], 0); chk("ovl_3", slog[b_log + 2], 1);
        end

        // Reset during STEP.
        btn_entry_n = 0; found = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (i == 6) btn_entry_n = 1;
            if (!up_n) found = 1;
        end
        btn_entry_n = 1;
        chk("rstep_seen", found, 1);
        reset = 1; tick();
        chk("rstep_up", up_n, 1); chk("rstep_gate", gate_open, 0); chk("rstep_busy", busy, 0);
        reset = 0; snap(); repeat (25) tick();
        chk("rstep_quiet", n_busy - b_busy, 0);

        // Reset during OPEN with an exit request pending.
        btn_entry_n = 0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 3) btn_exit_n = 0;
            if (i == 6) btn_entry_n = 1;
            if (i == 9) btn_exit_n = 1;
        end
        chk("ropen_gate_pre", gate_open, 1);
        reset = 1; tick();
        chk("ropen_up", up_n, 1); chk("ropen_gate", gate_open, 0); chk("ropen_busy", busy, 0);
        reset = 0; snap(); repeat (25) tick();
        chk("ropen_quiet", n_busy - b_busy, 0); chk("ropen_down", n_down - b_down, 0);

        // Inconsistent flags: both directions refused, no lockup.
        cnt_full = 1; cnt_empty = 1; snap();
        btn_entry_n = 0; btn_exit_n = 0; repeat (8) tick();
        btn_entry_n = 1; btn_exit_n = 1; repeat (20) tick();
        chk("both_flags_df", n_df - b_df, 1); chk("both_flags_de", n_de - b_de, 1);
        chk("both_flags_strobes", (n_up - b_up) + (n_down - b_down), 0);
        chk("both_flags_busy", n_busy - b_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
